conv_encoder_punct: RTL and testbench

- Transmit-side IEEE 802.11a convolutional encoder with puncturing. It is the counterpart of the receive-side Viterbi decoder path.
- Encodes the serial scrambled data stream with the K=7 code (g0=133, g1=171 octal). Supported rates are 1/2, 2/3 and 3/4.
- Emits the coded bits serially to the interleaver, with valid/ready handshakes on both sides.

---
 rtl/conv_encoder_punct.sv | 118 +++++++++++
 tb/tb_conv_encoder_punct.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_punct.sv
// K=7 convolutional encoder (802.11a, g0=133, g1=171) with rate 1/2, 2/3, 3/4
// puncturing. Serial in, serial out, valid/ready handshake on both sides.
module conv_encoder_punct #(
   parameter logic [6:0] G0 = 7'o133,
   parameter logic [6:0] G1 = 7'o171
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] rate_sel_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  logic       in_bit_i,
   input  logic       in_sof_i,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output logic       out_bit_o
);

   localparam logic [1:0] RATE_2_3 = 2'b01;
   localparam logic [1:0] RATE_3_4 = 2'b10;

   logic [5:0] sr_q, sr_d;
   logic [1:0] rate_q, rate_d;
   logic [1:0] ph_q, ph_d;
   logic [1:0] buf_q, buf_d;
   logic [1:0] cnt_q, cnt_d;

   logic       in_fire, out_fire;
   logic [6:0] win;
   logic       a_bit, b_bit;
   logic [1:0] rate_eff, ph_eff, ph_next;
   logic       emit_a, emit_b;

   // A new bit may enter in the same cycle the last pending bit leaves.
   assign in_ready_o  = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && out_ready_i);
   assign out_valid_o = (cnt_q != 2'd0);
   assign out_bit_o   = buf_q[1];
   assign in_fire     = in_valid_i && in_ready_o;
   assign out_fire    = out_valid_o && out_ready_i;

   // Generator window: bit 6 = current input, bit i<6 = input delayed 6-i.
   // A start-of-frame bit sees an all-zero history.
   assign win   = in_sof_i ? {in_bit_i, 6'b0}
                           : {in_bit_i, sr_q[0], sr_q[1], sr_q[2], sr_q[3], sr_q[4], sr_q[5]};
   assign a_bit = ^(win & G0);
   assign b_bit = ^(win & G1);

   // Puncture pattern selection for the bit being accepted.
   always_comb begin
      rate_eff = in_sof_i ? rate_sel_i : rate_q;
      ph_eff   = in_sof_i ? 2'd0 : ph_q;
      emit_a   = 1'b1;
      emit_b   = 1'b1;
      ph_next  = 2'd0;
      case (rate_eff)
         RATE_2_3: begin
            emit_b  = (ph_eff == 2'd0);
            ph_next = (ph_eff == 2'd0) ? 2'd1 : 2'd0;
         end
         RATE_3_4: begin
            emit_a  = (ph_eff != 2'd2);
            emit_b  = (ph_eff != 2'd1);
            ph_next = (ph_eff == 2'd2) ? 2'd0 : ph_eff + 2'd1;
         end
         default: begin
            emit_a  = 1'b1;
            emit_b  = 1'b1;
            ph_next = 2'd0;
         end
      endcase
   end

   // Next-state: drain the output buffer, then load coded bits of an accepted input.
   always_comb begin
      sr_d   = sr_q;
      rate_d = rate_q;
      ph_d   = ph_q;
      buf_d  = buf_q;
      cnt_d  = cnt_q;
      if (out_fire) begin
         buf_d = {buf_q[0], 1'b0};
         cnt_d = cnt_q - 2'd1;
      end
      if (in_fire) begin
         sr_d   = in_sof_i ? {5'b0, in_bit_i} : {sr_q[4:0], in_bit_i};
         rate_d = rate_eff;
         ph_d   = ph_next;
         if (emit_a && emit_b) begin
            buf_d = {a_bit, b_bit};
            cnt_d = 2'd2;
         end else if (emit_a) begin
            buf_d = {a_bit, 1'b0};
            cnt_d = 2'd1;
         end else begin
            buf_d = {b_bit, 1'b0};
            cnt_d = 2'd1;
         end
      end
   end

   // State registers with synchronous reset; reset discards any pending output.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sr_q   <= '0;
         rate_q <= '0;
         ph_q   <= '0;
         buf_q  <= '0;
         cnt_q  <= '0;
      end else begin
         sr_q   <= sr_d;
         rate_q <= rate_d;
         ph_q   <= ph_d;
         buf_q  <= buf_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Bench for conv_encoder_punct: frame table with spec-derived output sequences,
// plus a reference-model scoreboard checked on every output transfer.
module tb_conv_encoder_punct;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] rate_sel;
   logic       in_valid, in_ready, in_bit, in_sof;
   logic       out_valid, out_ready, out_bit;

   always #5 clk = ~clk;

   conv_encoder_punct dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .rate_sel_i  (rate_sel),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_bit_i    (in_bit),
      .in_sof_i    (in_sof),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_bit_o   (out_bit)
   );

   typedef struct {
      logic [1:0]  rate;
      int          n_in;
      logic [15:0] in_bits;   // bit i = i-th input bit
      int          n_out;
      logic [15:0] exp_out;   // bit i = i-th output bit
      int          stall_at;  // cycle at which a 5-cycle stall begins, -1 = none
      bit          chk_toggle;
   } vec_t;

   vec_t tbl[8];
   int   tests = 0;
   int   fails = 0;

   bit   sb[$];
   bit   got[$];

   logic [6:0] d_m;
   logic [1:0] rate_m;
   int         ph_m;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference encoder written directly from the tap equations.
   task automatic model_accept(input bit sof, input bit b, input logic [1:0] rs);
      bit a, bb;
      if (sof) begin
         d_m    = '0;
         rate_m = rs;
         ph_m   = 0;
      end
      a  = b ^ d_m[2] ^ d_m[3] ^ d_m[5] ^ d_m[6];
      bb = b ^ d_m[1] ^ d_m[2] ^ d_m[3] ^ d_m[6];
      case (rate_m)
         2'b01: begin
            sb.push_back(a);
            if (ph_m == 0) sb.push_back(bb);
            ph_m = (ph_m == 0) ? 1 : 0;
         end
         2'b10: begin
            if (ph_m != 2) sb.push_back(a);
            if (ph_m != 1) sb.push_back(bb);
            ph_m = (ph_m + 1) % 3;
         end
         default: begin
            sb.push_back(a);
            sb.push_back(bb);
         end
      endcase
      d_m[6:1] = {d_m[5:1], b};
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      int  idx = 0;
      int  cyc = 0;
      bit  hold = 1'b0;
      got.delete();
      while ((idx < v.n_in || sb.size() > 0) && cyc < 300) begin
         @(negedge clk);
         in_valid  = (idx < v.n_in);
         in_bit    = (idx < v.n_in) ? v.in_bits[idx] : 1'b0;
         in_sof    = (idx == 0);
         rate_sel  = (idx == 0) ? v.rate : 2'($urandom_range(0, 3));
         out_ready = !(v.stall_at >= 0 && cyc >= v.stall_at && cyc < v.stall_at + 5);
         #1;
         if (v.chk_toggle && cyc < 2 * v.n_in - 1)
            check({tag, " in_ready toggle"}, 32'(in_ready), 32'(cyc % 2 == 0));
         if (v.stall_at >= 0 && cyc == v.stall_at) begin
            check({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
            hold = out_bit;
         end else if (v.stall_at >= 0 && cyc > v.stall_at && cyc < v.stall_at + 5) begin
            check({tag, " stall out_bit stable"}, 32'(out_bit), 32'(hold));
            check({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
         end
         if (in_valid && in_ready) begin
            model_accept(in_sof, in_bit, rate_sel);
            idx++;
         end
         if (out_valid && out_ready) begin
            got.push_back(out_bit);
            if (sb.size() == 0) begin
               check({tag, " unexpected output"}, 32'd1, 32'd0);
            end else begin
               check({tag, " scoreboard bit"}, 32'(out_bit), 32'(sb.pop_front()));
            end
         end
         cyc++;
      end
      check({tag, " completed in budget"}, 32'(cyc < 300), 32'd1);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      check({tag, " output count"}, 32'(got.size()), 32'(v.n_out));
      for (int i = 0; i < v.n_out && i < got.size(); i++)
         check({tag, $sformatf(" out[%0d]", i)}, 32'(got[i]), 32'(v.exp_out[i]));
      // nothing further may appear once the frame has drained
      @(negedge clk);
      #1;
      check({tag, " idle after frame"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      tbl[0] = '{2'b00, 7, 16'h0001, 14, 16'h34FB, -1, 1'b1};  // impulse, 1/2
      tbl[1] = '{2'b00, 4, 16'h000F,  8, 16'h0067, -1, 1'b0};  // all ones, 1/2
      tbl[2] = '{2'b01, 2, 16'h0003,  3, 16'h0007, -1, 1'b0};  // 2/3, 2 ones
      tbl[3] = '{2'b01, 4, 16'h000F,  6, 16'h0037, -1, 1'b0};  // 2/3, 4 ones
      tbl[4] = '{2'b10, 3, 16'h0007,  4, 16'h000F, -1, 1'b0};  // 3/4, 3 ones
      tbl[5] = '{2'b10, 6, 16'h003F,  8, 16'h005F, -1, 1'b0};  // 3/4, 6 ones
      tbl[6] = '{2'b11, 4, 16'h000F,  8, 16'h0067, -1, 1'b0};  // reserved -> 1/2
      tbl[7] = '{2'b00, 7, 16'h0001, 14, 16'h34FB,  5, 1'b0};  // impulse with stall

      rst = 1'b1; rate_sel = 2'b00; in_valid = 1'b0; in_bit = 1'b0;
      in_sof = 1'b0; out_ready = 1'b1;
      d_m = '0; rate_m = 2'b00; ph_m = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset in_ready",  32'(in_ready),  32'd1);
      check("reset out_bit",   32'(out_bit),   32'd0);

      for (int i = 0; i < 8; i++)
         run_frame(tbl[i], $sformatf("frame%0d", i));

      // reset while two coded bits are pending
      @(negedge clk);
      in_valid = 1'b1; in_sof = 1'b1; in_bit = 1'b1; rate_sel = 2'b00; out_ready = 1'b0;
      #1;
      check("pre-reset in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0; in_sof = 1'b0; rst = 1'b1;
      #1;
      check("pre-reset out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      #1;
      check("post-reset out_valid", 32'(out_valid), 32'd0);
      check("post-reset in_ready",  32'(in_ready),  32'd1);
      check("post-reset out_bit",   32'(out_bit),   32'd0);
      sb.delete();

      run_frame(tbl[6], "restart_rsv");
      run_frame(tbl[3], "restart_2_3");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
